// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional ps2_clk deglitch filter enabled by defining PS2_RX_FILTER_EN.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       perr,
  output logic       ferr,
  output logic       busy,
  output logic [1:0] dbg_state,
  output logic [3:0] dbg_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state_q;
  logic [2:0]    clk_buf_q;
  logic [1:0]    data_buf_q;
  logic [9:0]    shift_q;
  logic [9:0]    shift_d;
  logic [3:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    rx_data_q;
  logic          rda_q;
  logic          perr_q;
  logic          ferr_q;
  logic          lvl_d;
  logic          fall_edge;
  logic          bit_d;
  logic          parity_ok;
  logic          stop_ok;

`ifdef PS2_RX_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;

  // Level only follows the pin after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_buf_q[0] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q     <= clk_buf_q[0];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign lvl_d = filt_q;
`else
  logic unused_filter;
  assign unused_filter = (FILTER_LEN > 0);
  assign lvl_d         = clk_buf_q[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_buf_q  <= 3'b111;
      data_buf_q <= 2'b11;
    end else begin
      clk_buf_q  <= {clk_buf_q[1], lvl_d, ps2_clk};
      data_buf_q <= {data_buf_q[0], ps2_data};
    end
  end

  assign fall_edge = (clk_buf_q[2:1] == 2'b10);
  assign bit_d     = data_buf_q[1];
  assign shift_d   = {bit_d, shift_q[9:1]};
  assign parity_ok = ^shift_q[8:0];
  assign stop_ok   = shift_q[9];

  // Payload register carries no reset; it is only read in DONE after ten fresh shifts.
  always_ff @(posedge clk) begin
    if (rx_en && (state_q == SHIFT) && fall_edge) begin
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      timer_q   <= '0;
      rx_data_q <= 8'h00;
      rda_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rda_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (!rx_en) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        timer_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fall_edge && !bit_d) begin
              state_q <= SHIFT;
              cnt_q   <= 4'd0;
              timer_q <= '0;
            end
          end
          SHIFT: begin
            if (fall_edge) begin
              cnt_q   <= cnt_q + 4'd1;
              timer_q <= '0;
              if (cnt_q == 4'd9) begin
                state_q <= DONE;
              end
            end else if (timer_q == TIMER_MAX) begin
              state_q <= IDLE;
              timer_q <= '0;
              ferr_q  <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            if (parity_ok && stop_ok) begin
              rx_data_q <= shift_q[7:0];
              rda_q     <= 1'b1;
            end
            perr_q <= !parity_ok;
            ferr_q <= !stop_ok;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rda       = rda_q;
  assign perr      = perr_q;
  assign ferr      = ferr_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule
